stopwatch_counter: RTL

- Time-keeping core of the stopwatch. Sits directly upstream of the 7-segment decode ROM.
- Counts tenths of a second while running, in BCD, over the range 0:00.0 to 9:59.9.
- Outputs four registered BCD digits. Each digit feeds the ROM's 4-bit number input (directly or via the display scanner).
- Start/stop and clear are single-cycle pulse inputs from the debounced button stage.

---
 rtl/stopwatch_counter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// BCD stopwatch core: counts tenths of a second from 0:00.0 to 9:59.9 and
// presents four registered digits plus run/wrap status for the display path.
//
// Control handshake: i_start_stop and i_clear are single-cycle pulses sampled
// on the rising edge; there is no ready/backpressure, every pulse is acted on.
module stopwatch_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic [3:0] o_tenths,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min,
  output logic       o_running,
  output logic       o_wrap,
  output logic [1:0] o_state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    tenths_n, sec_ones_n, sec_tens_n, min_n;
  logic          wrap_n;
  logic          tick;

  always_comb begin
    state_n    = state;
    presc_n    = presc;
    tenths_n   = o_tenths;
    sec_ones_n = o_sec_ones;
    sec_tens_n = o_sec_tens;
    min_n      = o_min;
    wrap_n     = 1'b0;
    tick       = (state == RUNNING) && (presc == DIV_M1);

    if (state == RUNNING) begin
      presc_n = tick ? '0 : presc + PW'(1);
    end

    // Ripple-carry BCD increment, all four digits settle in the same edge.
    if (tick) begin
      if (o_tenths == 4'd9) begin
        tenths_n = 4'd0;
        if (o_sec_ones == 4'd9) begin
          sec_ones_n = 4'd0;
          if (o_sec_tens == 4'd5) begin
            sec_tens_n = 4'd0;
            if (o_min == 4'd9) begin
              min_n  = 4'd0;
              wrap_n = 1'b1;
            end else begin
              min_n = o_min + 4'd1;
            end
          end else begin
            sec_tens_n = o_sec_tens + 4'd1;
          end
        end else begin
          sec_ones_n = o_sec_ones + 4'd1;
        end
      end else begin
        tenths_n = o_tenths + 4'd1;
      end
    end

    // Clear overrides everything, including a coincident tick or toggle.
    if (i_clear) begin
      state_n    = STOPPED;
      presc_n    = '0;
      tenths_n   = 4'd0;
      sec_ones_n = 4'd0;
      sec_tens_n = 4'd0;
      min_n      = 4'd0;
      wrap_n     = 1'b0;
    end else if (i_start_stop) begin
      case (state)
        STOPPED: state_n = RUNNING;
        RUNNING: state_n = PAUSED;
        PAUSED:  state_n = RUNNING;
        default: state_n = STOPPED;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= STOPPED;
      presc      <= '0;
      o_tenths   <= 4'd0;
      o_sec_ones <= 4'd0;
      o_sec_tens <= 4'd0;
      o_min      <= 4'd0;
      o_wrap     <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      o_tenths   <= tenths_n;
      o_sec_ones <= sec_ones_n;
      o_sec_tens <= sec_tens_n;
      o_min      <= min_n;
      o_wrap     <= wrap_n;
    end
  end

  assign o_running = (state == RUNNING);
  assign o_state   = state;

endmodule
